// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, screen geometry and winner codes for the Pong match logic
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_SCORED   = 3'd4,
        ST_GAMEOVER = 3'd5
    } state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CENTRE_X = 320;
    localparam int CENTRE_Y = 240;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/pong_score_cnt.sv
// rtl/pong_score_cnt.sv - 4-bit score counter with clear and increment, saturating at MAX
module pong_score_cnt #(
    parameter int MAX = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] cnt_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < 4'(MAX))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match sequencer: serve delay, goal detection, scoring, pause, ball gating
// Optional SPEEDUP_EN: ball_en bursts per frame grow with paddle hits.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7,
    parameter int LEFT_GOAL    = 20,
    parameter int RIGHT_GOAL   = 610,
    parameter int HITS_LOG2    = 2,
    parameter int MAX_SPEED    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_pulse,
    input  logic       pause_pulse,
    input  logic       paddle_hit,
    input  logic [9:0] ball_x,
    output logic       ball_en,
    output logic       ball_rst,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0] LG = 10'(LEFT_GOAL);
    localparam logic [9:0] RG = 10'(RIGHT_GOAL);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          scorer_left_q, scorer_left_d;
    logic          ball_en_q, ball_en_d;
    logic          ball_rst_q, ball_rst_d;
    logic          serve_dir_q, serve_dir_d;
    logic [1:0]    winner_q, winner_d;
    logic          inc_l, inc_r, clr_scores;
    logic          goal_l, goal_r, goal, tick_ok, new_win;

    assign goal_l  = (state_q == ST_PLAY) && (ball_x >= RG);
    assign goal_r  = (state_q == ST_PLAY) && (ball_x <= LG);
    assign goal    = goal_l || goal_r;
    assign tick_ok = (state_q == ST_PLAY) && frame_tick && !goal && !pause_pulse;
    assign new_win = scorer_left_q ? (score_l >= 4'(WIN_SCORE - 1))
                                   : (score_r >= 4'(WIN_SCORE - 1));

`ifdef SPEEDUP_EN
    logic [7:0] hit_q, hit_d, burst_q, burst_d, steps, speed_m1;
    assign steps    = hit_q >> HITS_LOG2;
    assign speed_m1 = (steps > 8'(MAX_SPEED - 1)) ? 8'(MAX_SPEED - 1) : steps;
`else
    logic unused_speedup;
    assign unused_speedup = paddle_hit ^ (HITS_LOG2 > 0) ^ (MAX_SPEED > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            scorer_left_q <= 1'b0;
            ball_en_q     <= 1'b0;
            ball_rst_q    <= 1'b1;
            serve_dir_q   <= 1'b1;
            winner_q      <= WIN_NONE;
`ifdef SPEEDUP_EN
            hit_q         <= '0;
            burst_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            scorer_left_q <= scorer_left_d;
            ball_en_q     <= ball_en_d;
            ball_rst_q    <= ball_rst_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
`ifdef SPEEDUP_EN
            hit_q         <= hit_d;
            burst_q       <= burst_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        scorer_left_d = scorer_left_q;
        case (state_q)
            ST_IDLE, ST_GAMEOVER: begin
                if (start_pulse) begin
                    state_d = ST_SERVE;
                    cnt_d   = CW'(SERVE_FRAMES);
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (cnt_q == CW'(1)) state_d = ST_PLAY;
                    else                 cnt_d   = cnt_q - CW'(1);
                end
            end
            ST_PLAY: begin
                // A goal outranks a same-cycle pause request
                if (goal) begin
                    state_d       = ST_SCORED;
                    scorer_left_d = goal_l;
                end else if (pause_pulse) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_pulse) state_d = ST_PLAY;
            end
            ST_SCORED: begin
                if (new_win) begin
                    state_d = ST_GAMEOVER;
                end else begin
                    state_d = ST_SERVE;
                    cnt_d   = CW'(SERVE_FRAMES);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ball_rst_d  = !((state_d == ST_PLAY) || (state_d == ST_PAUSE));
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        inc_l       = 1'b0;
        inc_r       = 1'b0;
        clr_scores  = 1'b0;
        ball_en_d   = tick_ok;
        if (((state_q == ST_IDLE) || (state_q == ST_GAMEOVER)) && start_pulse) begin
            clr_scores  = 1'b1;
            winner_d    = WIN_NONE;
            serve_dir_d = 1'b1;
        end
        if (state_q == ST_SCORED) begin
            inc_l       = scorer_left_q;
            inc_r       = !scorer_left_q;
            serve_dir_d = scorer_left_q;
            if (new_win) winner_d = scorer_left_q ? WIN_LEFT : WIN_RIGHT;
        end
`ifdef SPEEDUP_EN
        burst_d = '0;
        if (tick_ok) begin
            burst_d = speed_m1;
        end else if ((state_q == ST_PLAY) && !goal && !pause_pulse && (burst_q != 8'd0)) begin
            ball_en_d = 1'b1;
            burst_d   = burst_q - 8'd1;
        end
        hit_d = hit_q;
        if ((state_d == ST_SERVE) && (state_q != ST_SERVE)) begin
            hit_d = '0;
        end else if ((state_q == ST_PLAY) && paddle_hit && (hit_q != 8'hFF)) begin
            hit_d = hit_q + 8'd1;
        end
`endif
    end

    pong_score_cnt #(.MAX(WIN_SCORE)) u_score_l (
        .clk   (clk),
        .reset (reset),
        .inc_i (inc_l),
        .clr_i (clr_scores),
        .cnt_o (score_l)
    );

    pong_score_cnt #(.MAX(WIN_SCORE)) u_score_r (
        .clk   (clk),
        .reset (reset),
        .inc_i (inc_r),
        .clr_i (clr_scores),
        .cnt_o (score_r)
    );

    assign ball_en   = ball_en_q;
    assign ball_rst  = ball_rst_q;
    assign serve_dir = serve_dir_q;
    assign winner    = winner_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - directed plus randomized self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;
    import pong_pkg::*;

    localparam int SF = 3;
    localparam int HL = 2;
    localparam int MS = 4;
`ifdef SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0, start_pulse = 1'b0, pause_pulse = 1'b0, paddle_hit = 1'b0;
    logic [9:0] ball_x = 10'd320;
    logic       ball_en, ball_rst, serve_dir;
    logic [3:0] score_l, score_r;
    logic [1:0] winner;
    logic [2:0] state;

    int n_cmp = 0, n_bad = 0;
    int en_seen = 0, first_off = -1, cyc_idx = 0;
    int m_l = 0, m_r = 0, m_win = 0, m_dir = 1, m_hits = 0;

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .SERVE_FRAMES (SF),
        .WIN_SCORE    (7),
        .LEFT_GOAL    (20),
        .RIGHT_GOAL   (610),
        .HITS_LOG2    (HL),
        .MAX_SPEED    (MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .start_pulse (start_pulse),
        .pause_pulse (pause_pulse),
        .paddle_hit  (paddle_hit),
        .ball_x      (ball_x),
        .ball_en     (ball_en),
        .ball_rst    (ball_rst),
        .serve_dir   (serve_dir),
        .score_l     (score_l),
        .score_r     (score_r),
        .winner      (winner),
        .state       (state)
    );

    function automatic int exp_speed(input int hits);
        int s;
        s = hits >> HL;
        if (s > MS - 1) s = MS - 1;
        return SPEEDUP ? 1 + s : 1;
    endfunction

    function automatic logic [9:0] rand_x(input bit left_scores);
        return left_scores ? 10'($urandom_range(610, 639)) : 10'($urandom_range(0, 20));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (ball_en === 1'b1) begin
            if (first_off < 0) first_off = cyc_idx;
            en_seen++;
        end
        cyc_idx++;
        chk("en_rst_exclusive", int'(ball_en & ball_rst), 0);
        frame_tick = 1'b0; start_pulse = 1'b0; pause_pulse = 1'b0; paddle_hit = 1'b0;
    endtask

    task automatic win_reset();
        en_seen = 0; first_off = -1; cyc_idx = 0;
    endtask

    task automatic frame();
        win_reset();
        frame_tick = 1'b1;
        repeat (8) cyc();
    endtask

    task automatic check_all(input string tag, input int st);
        chk({tag, ":state"}, int'(state), st);
        chk({tag, ":score_l"}, int'(score_l), m_l);
        chk({tag, ":score_r"}, int'(score_r), m_r);
        chk({tag, ":winner"}, int'(winner), m_win);
        chk({tag, ":serve_dir"}, int'(serve_dir), m_dir);
    endtask

    task automatic serve_to_play();
        for (int f = 1; f <= SF; f++) begin
            chk("serve_rst", int'(ball_rst), 1);
            chk("serve_state", int'(state), ST_SERVE);
            frame();
            chk("serve_no_en", en_seen, 0);
        end
        chk("play_state", int'(state), ST_PLAY);
        chk("play_rst", int'(ball_rst), 0);
    endtask

    task automatic play_frames(input int n, input int hits_max);
        for (int f = 0; f < n; f++) begin
            ball_x = 10'($urandom_range(21, 609));
            for (int h = $urandom_range(0, hits_max); h > 0; h--) begin
                paddle_hit = 1'b1;
                cyc();
                m_hits++;
            end
            frame();
            chk("frame_pulses", en_seen, exp_speed(m_hits));
            chk("frame_first_off", first_off, 0);
        end
        ball_x = 10'd320;
    endtask

    task automatic goal(input bit left, input logic [9:0] x);
        win_reset();
        ball_x = x;
        cyc();
        chk("scored_state", int'(state), ST_SCORED);
        ball_x = 10'd320;
        cyc();
        if (left) m_l++; else m_r++;
        m_dir = left ? 1 : 0;
        m_hits = 0;
        if (m_l == 7 || m_r == 7) m_win = left ? 1 : 2;
        check_all("goal", (m_win != 0) ? ST_GAMEOVER : ST_SERVE);
        chk("goal_rst", int'(ball_rst), 1);
        chk("goal_no_en", en_seen, 0);
    endtask

    initial begin
        int guard;
        bit lft;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", ST_IDLE);
        chk("reset_en", int'(ball_en), 0);
        chk("reset_rst", int'(ball_rst), 1);
        reset = 1'b0;

        frame();
        chk("idle_no_en", en_seen, 0);
        pause_pulse = 1'b1;
        cyc();
        chk("idle_pause_ignored", int'(state), ST_IDLE);
        start_pulse = 1'b1;
        cyc();
        check_all("start", ST_SERVE);

        serve_to_play();
        play_frames(1, 0);
        ball_x = 10'd21;  cyc(); chk("x21_no_goal", int'(state), ST_PLAY);
        ball_x = 10'd609; cyc(); chk("x609_no_goal", int'(state), ST_PLAY);
        ball_x = 10'd320;

        goal(1'b0, 10'd15);
        serve_to_play();
        start_pulse = 1'b1;
        cyc();
        check_all("start_in_play", ST_PLAY);

        pause_pulse = 1'b1;
        cyc();
        chk("pause_state", int'(state), ST_PAUSE);
        for (int i = 0; i < 5; i++) begin
            frame();
            chk("pause_no_en", en_seen, 0);
            chk("pause_rst", int'(ball_rst), 0);
        end
        ball_x = 10'd5;
        cyc();
        chk("pause_goal_ignored", int'(state), ST_PAUSE);
        ball_x = 10'd320;
        pause_pulse = 1'b1;
        cyc();
        chk("resume_state", int'(state), ST_PLAY);
        play_frames(1, 0);

        win_reset();
        ball_x = 10'd612; pause_pulse = 1'b1; frame_tick = 1'b1;
        cyc();
        chk("goal_beats_pause", int'(state), ST_SCORED);
        ball_x = 10'd320;
        cyc();
        m_l++; m_dir = 1; m_hits = 0;
        check_all("goal_pause_tick", ST_SERVE);
        repeat (4) cyc();
        chk("goal_pause_no_en", en_seen, 0);

        serve_to_play();
        repeat (8) begin paddle_hit = 1'b1; cyc(); m_hits++; end
        play_frames(1, 0);
        repeat (12) begin paddle_hit = 1'b1; cyc(); m_hits++; end
        play_frames(1, 0);

        win_reset();
        frame_tick = 1'b1;
        cyc();
        pause_pulse = 1'b1;
        cyc();
        repeat (6) cyc();
        chk("burst_abort_pulses", en_seen, 1);
        chk("burst_abort_state", int'(state), ST_PAUSE);
        pause_pulse = 1'b1;
        cyc();
        play_frames(3, 6);

        goal(1'b1, 10'd610);
        serve_to_play();
        play_frames(1, 0);
        goal(1'b0, 10'd20);
        serve_to_play();
        play_frames(1, 3);

        guard = 0;
        while (m_win == 0 && guard < 20) begin
            goal(1'b1, rand_x(1'b1));
            if (m_win == 0) begin
                serve_to_play();
                play_frames($urandom_range(1, 2), 5);
            end
            guard++;
        end
        chk("left_wins", m_win, 1);
        frame();
        chk("gameover_no_en", en_seen, 0);
        chk("gameover_rst", int'(ball_rst), 1);
        pause_pulse = 1'b1;
        cyc();
        check_all("gameover_hold", ST_GAMEOVER);

        start_pulse = 1'b1;
        cyc();
        m_l = 0; m_r = 0; m_win = 0; m_dir = 1; m_hits = 0;
        check_all("restart", ST_SERVE);
        serve_to_play();

        guard = 0;
        while (m_win == 0 && guard < 20) begin
            play_frames($urandom_range(1, 2), 5);
            lft = 1'($urandom_range(0, 1));
            goal(lft, rand_x(lft));
            if (m_win == 0) serve_to_play();
            guard++;
        end

        start_pulse = 1'b1;
        cyc();
        m_l = 0; m_r = 0; m_win = 0; m_dir = 1; m_hits = 0;
        serve_to_play();
        play_frames(1, 4);
        goal(1'b0, rand_x(1'b0));
        serve_to_play();
        reset = 1'b1;
        cyc();
        m_l = 0; m_r = 0; m_win = 0; m_dir = 1; m_hits = 0;
        check_all("mid_reset", ST_IDLE);
        chk("mid_reset_rst", int'(ball_rst), 1);
        chk("mid_reset_en", int'(ball_en), 0);
        reset = 1'b0;
        cyc();
        chk("post_reset_idle", int'(state), ST_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
